// File: rtl/gnrl_ram_pd_ctrl.sv
// gnrl_ram_pd_ctrl: valid/ready front end for a pseudo-dual-port RAM.
// The RAM has a 1-cycle registered read and a byte-masked write.
// Writes pass straight through to the RAM write port.
// Reads are tracked for one stage (s1), then captured into a small response FIFO.
// A credit check keeps every read that is in flight guaranteed a FIFO slot.
// A read and a write accepted to the same word in the same cycle give write-first data.
module gnrl_ram_pd_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wreq_valid_i,
  output logic                    wreq_ready_o,
  input  logic [ADDR_WIDTH-1:0]   wreq_addr_i,
  input  logic [DATA_WIDTH-1:0]   wreq_data_i,
  input  logic [DATA_WIDTH/8-1:0] wreq_mask_i,
  input  logic                    rreq_valid_i,
  output logic                    rreq_ready_o,
  input  logic [ADDR_WIDTH-1:0]   rreq_addr_i,
  output logic                    rresp_valid_o,
  input  logic                    rresp_ready_i,
  output logic [DATA_WIDTH-1:0]   rresp_data_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_we_mask_o,
  output logic [ADDR_WIDTH-1:0]   ram_waddr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic [ADDR_WIDTH-1:0]   ram_raddr_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int OFS = (DATA_WIDTH == 64) ? 3 : 2;
  localparam int MW  = DATA_WIDTH / 8;
  localparam int PW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW  = $clog2(RESP_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(RESP_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(RESP_DEPTH - 1);

  // Read stage 1: a read accepted last cycle whose RAM data is on ram_rdata_i now
  logic                  s1_v_reg;
  logic                  hz_v_reg;
  logic [DATA_WIDTH-1:0] hz_data_reg;
  logic [MW-1:0]         hz_mask_reg;

  // Response FIFO state
  logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic [DATA_WIDTH-1:0] head_reg;

  logic                  w_acc;
  logic                  r_acc;
  logic                  deq;
  logic                  enq;
  logic                  same_word;
  logic [CW:0]           credit_used;
  logic [PW-1:0]         rd_ptr_inc;
  logic [PW-1:0]         wr_ptr_inc;
  logic [DATA_WIDTH-1:0] enq_data;

  // Circular pointer advance that wraps at the last slot
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  // Write channel is a direct pass-through to the RAM write port
  assign wreq_ready_o  = !rst;
  assign w_acc         = wreq_valid_i & wreq_ready_o;
  assign ram_we_o      = w_acc;
  assign ram_we_mask_o = wreq_mask_i;
  assign ram_waddr_o   = wreq_addr_i;
  assign ram_wdata_o   = wreq_data_i;

  // Read address always drives the RAM; the RAM only matters when a read is accepted
  assign ram_raddr_o = rreq_addr_i;

  // Slots in use are buffered entries plus the read in stage 1, less the one leaving now.
  // Admitting a read only while this is below the depth guarantees it a slot later.
  assign rresp_valid_o = (count_reg != '0);
  assign deq           = rresp_valid_o & rresp_ready_i;
  assign credit_used   = {1'b0, count_reg} + (CW + 1)'(s1_v_reg) - (CW + 1)'(deq);
  assign rreq_ready_o  = !rst & (credit_used < DEPTH_C);
  assign r_acc         = rreq_valid_i & rreq_ready_o;

  assign same_word = (wreq_addr_i[ADDR_WIDTH-1:OFS] == rreq_addr_i[ADDR_WIDTH-1:OFS]);

  // Data from stage 1 lands in the FIFO on this edge
  assign enq        = s1_v_reg;
  assign rd_ptr_inc = ptr_inc(rd_ptr_reg);
  assign wr_ptr_inc = ptr_inc(wr_ptr_reg);

  // Write-first merge: bytes written in the read's accept cycle override the old RAM bytes
  generate
    for (genvar gi = 0; gi < MW; gi++) begin : g_merge
      assign enq_data[gi*8 +: 8] = (hz_v_reg && hz_mask_reg[gi]) ? hz_data_reg[gi*8 +: 8]
                                                                 : ram_rdata_i[gi*8 +: 8];
    end
  endgenerate

  // Stage 1 tracking: inflight flag plus captured write for the same-word hazard
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_reg    <= 1'b0;
      hz_v_reg    <= 1'b0;
      hz_data_reg <= '0;
      hz_mask_reg <= '0;
    end else begin
      s1_v_reg    <= r_acc;
      hz_v_reg    <= r_acc & w_acc & same_word;
      hz_data_reg <= wreq_data_i;
      hz_mask_reg <= wreq_mask_i;
    end
  end

  // FIFO storage; pointers define which entries are live, so no reset is needed
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_mem[wr_ptr_reg] <= enq_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq) begin
        wr_ptr_reg <= wr_ptr_inc;
      end
      if (deq) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      count_reg <= count_reg + CW'(enq) - CW'(deq);
    end
  end

  // Registered head entry: loads from the incoming word when the FIFO is (becoming) empty,
  // otherwise from the next stored entry on a dequeue, and holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= '0;
    end else if (enq && ((count_reg == '0) || (deq && (count_reg == CW'(1))))) begin
      head_reg <= enq_data;
    end else if (deq && (count_reg > CW'(1))) begin
      head_reg <= fifo_mem[rd_ptr_inc];
    end
  end

  assign rresp_data_o = head_reg;

endmodule

// File: tb/tb_gnrl_ram_pd_ctrl.sv
// Testbench for gnrl_ram_pd_ctrl: a behavioural RAM is attached to the RAM port.
// A reference model tracks the outstanding responses as a queue of {data, earliest cycle}.
// A read's expected data comes from a reference memory with any same-cycle write applied.
module tb_gnrl_ram_pd_ctrl;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic mem_load;
  logic [31:0] seed;

  // 32-bit instance
  logic        wv, wready, rv, rready, rvalid, rr, ram_we;
  logic [15:0] wa, ra, ram_waddr, ram_raddr;
  logic [31:0] wd, rdata, ram_wdata, ram_rdata;
  logic [3:0]  wm, ram_mask;

  gnrl_ram_pd_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .RESP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wreq_valid_i(wv), .wreq_ready_o(wready), .wreq_addr_i(wa), .wreq_data_i(wd), .wreq_mask_i(wm),
    .rreq_valid_i(rv), .rreq_ready_o(rready), .rreq_addr_i(ra),
    .rresp_valid_o(rvalid), .rresp_ready_i(rr), .rresp_data_o(rdata),
    .ram_we_o(ram_we), .ram_we_mask_o(ram_mask), .ram_waddr_o(ram_waddr),
    .ram_wdata_o(ram_wdata), .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata)
  );

  // 64-bit instance
  logic        w64v, wready64, r64v, rready64, rvalid64, r64rr, ram_we64;
  logic [15:0] w64a, r64a, ram_waddr64, ram_raddr64;
  logic [63:0] w64d, rdata64, ram_wdata64, ram_rdata64;
  logic [7:0]  w64m, ram_mask64;

  gnrl_ram_pd_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .RESP_DEPTH(DEPTH)) dut64 (
    .clk(clk), .rst(rst),
    .wreq_valid_i(w64v), .wreq_ready_o(wready64), .wreq_addr_i(w64a), .wreq_data_i(w64d),
    .wreq_mask_i(w64m),
    .rreq_valid_i(r64v), .rreq_ready_o(rready64), .rreq_addr_i(r64a),
    .rresp_valid_o(rvalid64), .rresp_ready_i(r64rr), .rresp_data_o(rdata64),
    .ram_we_o(ram_we64), .ram_we_mask_o(ram_mask64), .ram_waddr_o(ram_waddr64),
    .ram_wdata_o(ram_wdata64), .ram_raddr_o(ram_raddr64), .ram_rdata_i(ram_rdata64)
  );

  function automatic logic [31:0] init_word(input logic [31:0] s, input int i);
    return (s ^ (32'(i) * 32'h9E3779B9)) * 32'h85EBCA6B + 32'(i);
  endfunction

  // Behavioural RAMs: 1-cycle registered read returning the pre-write value, byte-masked write
  logic [31:0] ram32 [0:63];
  logic [63:0] ram64 [0:31];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) ram32[i] <= init_word(seed, i);
      for (int i = 0; i < 32; i++) ram64[i] <= 64'h0;
    end else begin
      if (ram_we)
        for (int b = 0; b < 4; b++)
          if (ram_mask[b]) ram32[ram_waddr[7:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      if (ram_we64)
        for (int b = 0; b < 8; b++)
          if (ram_mask64[b]) ram64[ram_waddr64[7:3]][b*8 +: 8] <= ram_wdata64[b*8 +: 8];
    end
    ram_rdata   <= ram32[ram_raddr[7:2]];
    ram_rdata64 <= ram64[ram_raddr64[7:3]];
  end

  // Reference model state
  typedef struct {
    logic [31:0] d;
    int          avail;
  } resp_t;
  resp_t       q[$];
  logic [31:0] ref_mem [0:63];
  int          cyc;
  bit          seen;
  int          checks;
  int          failures;
  logic        acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle on the 32-bit instance: drive, check against the model, advance the model
  task automatic step(input logic i_wv, input logic [15:0] i_wa, input logic [31:0] i_wd,
                      input logic [3:0] i_wm, input logic i_rv, input logic [15:0] i_ra,
                      input logic i_rr, input logic i_rs, output logic o_acc);
    logic        ev, edq, erdy, wacc;
    logic [31:0] rd;
    resp_t       e;
    wv = i_wv; wa = i_wa; wd = i_wd; wm = i_wm;
    rv = i_rv; ra = i_ra; rr = i_rr; rst = i_rs;
    #1;
    ev   = (q.size() > 0) && (q[0].avail <= cyc);
    edq  = ev && i_rr;
    erdy = !i_rs && ((q.size() - int'(edq)) < DEPTH);
    wacc = i_wv && !i_rs;
    check("wreq_ready", wready, !i_rs);
    check("ram_we", ram_we, wacc);
    check("ram_waddr", ram_waddr, i_wa);
    check("ram_wdata", ram_wdata, i_wd);
    check("ram_mask", ram_mask, i_wm);
    check("ram_raddr", ram_raddr, i_ra);
    check("rreq_ready", rready, erdy);
    check("rresp_valid", rvalid, ev);
    if (ev) begin
      check("rresp_data", rdata, q[0].d);
      seen = 1'b1;
    end else if (!seen) begin
      check("rresp_data_zero", rdata, 64'h0);
    end
    o_acc = i_rv && erdy;
    if (edq) void'(q.pop_front());
    if (o_acc) begin
      rd = ref_mem[i_ra[7:2]];
      if (wacc && (i_wa[15:2] == i_ra[15:2]))
        for (int b = 0; b < 4; b++)
          if (i_wm[b]) rd[b*8 +: 8] = i_wd[b*8 +: 8];
      e.d = rd;
      e.avail = cyc + 2;
      q.push_back(e);
    end
    if (wacc)
      for (int b = 0; b < 4; b++)
        if (i_wm[b]) ref_mem[i_wa[7:2]][b*8 +: 8] = i_wd[b*8 +: 8];
    if (i_rs) begin
      q.delete();
      seen = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic i_rr);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 16'h0, i_rr, 1'b0, a);
  endtask

  initial begin
    int k;
    checks = 0; failures = 0; cyc = 0; seen = 1'b1;
    seed = $urandom;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(seed, i);
    rst = 1'b1; mem_load = 1'b1;
    wv = 0; wa = 0; wd = 0; wm = 0; rv = 0; ra = 0; rr = 1;
    w64v = 0; w64a = 0; w64d = 0; w64m = 0; r64v = 0; r64a = 0; r64rr = 1;
    @(posedge clk);
    #1;
    mem_load = 1'b0;
    seen = 1'b0;

    // Reset held: outputs quiet, data register cleared
    step(1'b1, 16'h0004, 32'h12345678, 4'hF, 1'b1, 16'h0004, 1'b1, 1'b1, acc);
    idle(2, 1'b1);

    // Basic read two cycles after a full-word write
    step(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b0, 16'h0, 1'b1, 1'b0, acc);
    idle(1, 1'b1);
    step(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0010, 1'b1, 1'b0, acc);
    idle(4, 1'b1);

    // Same-cycle hazard, then a re-read of the merged word
    step(1'b1, 16'h0020, 32'h11223344, 4'hF, 1'b0, 16'h0, 1'b1, 1'b0, acc);
    idle(1, 1'b1);
    step(1'b1, 16'h0020, 32'hAABBCCDD, 4'h5, 1'b1, 16'h0022, 1'b1, 1'b0, acc);
    check("hazard_model", q[$].d, 32'h11BB33DD);
    idle(3, 1'b1);
    step(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0020, 1'b1, 1'b0, acc);
    idle(4, 1'b1);

    // Back-pressure: consumer stalled for 5 cycles while three reads are offered
    k = 0;
    for (int c = 0; c < 16 && k < 3; c++) begin
      step(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'(k * 4), (c >= 5), 1'b0, acc);
      if (acc) k++;
    end
    idle(5, 1'b1);

    // Streaming: 16 back-to-back reads with a ready consumer
    for (int i = 0; i < 16; i++)
      step(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'(i * 4), 1'b1, 1'b0, acc);
    idle(4, 1'b1);

    // Reset mid-flight, then a fresh read
    step(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0010, 1'b0, 1'b0, acc);
    step(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0014, 1'b0, 1'b0, acc);
    step(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 16'h0, 1'b0, 1'b0, acc);
    step(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 16'h0, 1'b0, 1'b1, acc);
    idle(2, 1'b1);
    step(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0010, 1'b1, 1'b0, acc);
    idle(4, 1'b1);

    // Randomized traffic over a few words to provoke hazards and stalls
    for (int i = 0; i < 500; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), $urandom, 4'($urandom),
           ($urandom_range(0, 2) != 0), 16'($urandom_range(0, 31)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 96) == 0), acc);
    idle(6, 1'b1);

    // 64-bit instance: upper-half masked write over zero, read through the other half-word
    w64v = 1; w64a = 16'h0008; w64d = 64'h01234567_89ABCDEF; w64m = 8'hF0;
    #1;
    check("w64_ram_we", ram_we64, 1'b1);
    @(posedge clk);
    #1;
    w64v = 0; r64v = 1; r64a = 16'h000C;
    #1;
    check("r64_ready", rready64, 1'b1);
    @(posedge clk);
    #1;
    r64v = 0;
    #1;
    check("r64_valid_t1", rvalid64, 1'b0);
    @(posedge clk);
    #1;
    check("r64_valid_t2", rvalid64, 1'b1);
    check("r64_data", rdata64, 64'h01234567_00000000);
    @(posedge clk);
    #1;
    check("r64_drained", rvalid64, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
